// File: rtl/alu_pkg.sv
// Shared definitions for the alu4 datapath and its operand entry front end.
package alu_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw bouncy button, debounces it, and emits a one-cycle
// registered pulse on each debounced rising edge.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_s;
  logic                   btn_db;
  logic                   btn_db_prev;
  logic [CW-1:0]          count;

  assign btn_s = btn_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // The level only flips after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      count  <= '0;
    end else if (btn_s == btn_db) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      btn_db <= btn_s;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_prev <= 1'b0;
      press       <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      press       <= btn_db & ~btn_db_prev;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Lets a user enter operand A, operand B and the opcode from slide switches,
// one button press each, and holds them as registered inputs for alu4.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] sw,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] opcode,
  output logic       ready,
  output logic       start,
  output logic [3:0] state_leds
);

  seq_state_t state;
  logic       press;
  logic [3:0] sw_sync [SYNC_STAGES];
  logic [3:0] sw_s;

  assign sw_s = sw_sync[SYNC_STAGES-1];

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn),
    .press  (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  // ready, start and the LEDs are registered alongside the state so they
  // change on the same edge as the transition that causes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      a          <= '0;
      b          <= '0;
      opcode     <= OP_MULT;
      ready      <= 1'b0;
      start      <= 1'b0;
      state_leds <= 4'b0001;
    end else begin
      start <= 1'b0;
      if (press) begin
        case (state)
          LOAD_A: begin
            a          <= sw_s;
            state      <= LOAD_B;
            state_leds <= 4'b0010;
          end
          LOAD_B: begin
            b          <= sw_s;
            state      <= LOAD_OP;
            state_leds <= 4'b0100;
          end
          LOAD_OP: begin
            opcode     <= sw_s[1:0];
            state      <= SHOW;
            ready      <= 1'b1;
            start      <= 1'b1;
            state_leds <= 4'b1000;
          end
          SHOW: begin
            state      <= LOAD_A;
            ready      <= 1'b0;
            state_leds <= 4'b0001;
          end
          default: begin
            state      <= LOAD_A;
            ready      <= 1'b0;
            state_leds <= 4'b0001;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream stage of alu4. Lets a user enter operand A, operand B and the opcode one after another from four slide switches and one push button, then presents them as stable registered values to the ALU's a, b and opcode inputs. It contains the button synchroniser, debouncer and edge detector, and a 4-state entry FSM. It drives one-hot status LEDs and a one-cycle start pulse for downstream capture logic.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles the synchronised button must differ from its debounced level before that level flips (minimum 2).
SYNC_STAGES, 2, flip-flop depth of the button and switch synchronisers (minimum 2).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
btn  input  1  raw push button, active-high, asynchronous and bouncy
sw  input  4  raw slide switches, asynchronous, quasi-static
a  output  4  operand A to alu4.a
b  output  4  operand B to alu4.b
opcode  output  2  to alu4.opcode (00 mult, 01 and, 10 xor, 11 sub)
ready  output  1  high while in SHOW; a, b and opcode form a complete set
start  output  1  one-cycle pulse in the first cycle of SHOW
state_leds  output  4  one-hot current state: bit0 LOAD_A, bit1 LOAD_B, bit2 LOAD_OP, bit3 SHOW

Behaviour:
- Reset (async assert, release synchronous to clk):
  - a=0, b=0, opcode=00, ready=0, start=0, state=LOAD_A, state_leds=0001.
  - Synchroniser flops, debounced level, debounce counter and press flag all clear to 0.
- Synchronisers:
  - btn and each sw bit pass through SYNC_STAGES flops, giving btn_s and sw_s.
  - Only sw_s is ever captured.
- Debouncer:
  - Counter resets to 0 in any cycle where btn_s equals the debounced level btn_db.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_db takes btn_s and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change btn_db.
- Press detect:
  - press is a registered one-cycle pulse, high in the cycle after btn_db goes 0->1.
  - Release (1->0) produces nothing. Holding the button produces exactly one press.
- FSM, acting only on press:
  - LOAD_A: a <= sw_s; go to LOAD_B.
  - LOAD_B: b <= sw_s; go to LOAD_OP.
  - LOAD_OP: opcode <= sw_s[1:0] (sw_s[3:2] ignored); go to SHOW.
  - SHOW: go to LOAD_A. a, b and opcode are not cleared; each holds until overwritten in its own load state.
  - With no press, the state and all operand registers hold.
- Outputs:
  - ready = (state==SHOW), registered with the state.
  - start is high exactly in the first cycle ready is high, i.e. the cycle the FSM enters SHOW.
  - state_leds is decoded from the registered state, one-hot at all times.
- Latency:
  - Switches captured in the state register at the same clock edge as the transition.
  - New a, b or opcode values are visible the cycle after press.
- Boundaries:
  - Reset mid-debounce or mid-entry discards any partial entry and returns to LOAD_A with zeroed operands.
  - A press cannot occur in two consecutive cycles (guaranteed by the debouncer), so each load state is skipped never.
  - A switch change during the capture edge may be captured as either value; this is acceptable.
  - All registers are plain (no X propagation); there is no illegal-state recovery beyond a default branch to LOAD_A with ready=0.

Decomposition:
- Shared package alu_pkg:
  - enum typedef seq_state_t {LOAD_A, LOAD_B, LOAD_OP, SHOW}.
  - Opcode constants OP_MULT=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_SUB=2'b11.
  - alu4 is updated later to import the opcode constants.
- Sub-module button_debounce:
  - Contains the synchroniser, counter and press pulse. Parameters SYNC_STAGES and DEBOUNCE_CYCLES; ports clk, rst, btn_raw, press.
  - Reused for future buttons.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: assert rst mid-clock -> a=0, b=0, opcode=00, ready=0, start=0, state_leds=0001 immediately, without waiting for a clock edge.
- Full entry: sw=0101 press, sw=1110 press, sw=0011 press (each hold of 10 cycles) -> a=0101, b=1110, opcode=11, ready=1, start high for exactly 1 cycle, state_leds=1000.
- Bounce rejection: btn toggles 1,0,1,0 with 2-cycle pulses, then held high for 20 cycles -> exactly one press, FSM advances by one state only.
- Held button: btn high for 200 cycles in LOAD_A -> single transition to LOAD_B; release produces no further transition.
- Wrap and retention: from SHOW, press with sw=1111 -> state LOAD_A, ready=0, a/b/opcode unchanged; next press with sw=1111 -> a=1111, b unchanged.
- Reset mid-entry: after A and B are loaded, assert rst during a debounce count -> LOAD_A, operands cleared; the pending press is lost and no start pulse is seen.
